// File: rtl/vga_timing_ctrl.sv
// Raster timing generator: issues one pixel request per active position and drives registered sync/DE/RGB pins.
// Counter-to-pin latency is 2 cycles on every output; there is no backpressure, so the buffer must answer every request one cycle later.
module vga_timing_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 12
) (
  input  logic        clk_v,
  input  logic        resetn_v,
  input  logic        en_i,
  input  logic [11:0] data_i,
  output logic        data_req_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic [3:0]  red_o,
  output logic [3:0]  green_o,
  output logic [3:0]  blue_o,
  output logic        frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  // Decode bounds carry one extra bit so a sync pulse ending exactly at TOTAL = 2^CNT_W still compares correctly.
  localparam logic [CNT_W:0] H_ACT  = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] HS_BEG = (CNT_W+1)'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W:0] HS_END = (CNT_W+1)'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W:0] V_ACT  = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] VS_BEG = (CNT_W+1)'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W:0] VS_END = (CNT_W+1)'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  logic             run;
  logic [CNT_W:0]   h_ext;
  logic [CNT_W:0]   v_ext;
  logic             act0;
  logic             hs0;
  logic             vs0;
  logic             fs0;

  logic             act1;
  logic             hs1;
  logic             vs1;
  logic             fs1;

  // Leaving RUN is only possible at the last position of a frame, so a started frame always completes.
  always_ff @(posedge clk_v or negedge resetn_v) begin
    if (!resetn_v) begin
      state <= ST_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          h_cnt <= '0;
          v_cnt <= '0;
          if (en_i) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
              v_cnt <= '0;
              if (!en_i) begin
                state <= ST_IDLE;
              end
            end else begin
              v_cnt <= v_cnt + ONE;
            end
          end else begin
            h_cnt <= h_cnt + ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          h_cnt <= '0;
          v_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    run   = (state == ST_RUN);
    h_ext = {1'b0, h_cnt};
    v_ext = {1'b0, v_cnt};
    act0  = run && (h_ext < H_ACT) && (v_ext < V_ACT);
    hs0   = run && (h_ext >= HS_BEG) && (h_ext < HS_END);
    vs0   = run && (v_ext >= VS_BEG) && (v_ext < VS_END);
    fs0   = run && (h_cnt == '0) && (v_cnt == '0);
  end

  assign data_req_o = act0;

  // Stage 1: the buffer's pixel for the request made in stage 0 is on data_i during this stage.
  always_ff @(posedge clk_v or negedge resetn_v) begin
    if (!resetn_v) begin
      act1 <= 1'b0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      fs1  <= 1'b0;
    end else begin
      act1 <= act0;
      hs1  <= hs0;
      vs1  <= vs0;
      fs1  <= fs0;
    end
  end

  // Stage 2: every pin comes straight from a flop so sync, DE and colour leave aligned.
  always_ff @(posedge clk_v or negedge resetn_v) begin
    if (!resetn_v) begin
      de_o          <= 1'b0;
      hsync_o       <= ~HSYNC_POL;
      vsync_o       <= ~VSYNC_POL;
      frame_start_o <= 1'b0;
      red_o         <= 4'h0;
      green_o       <= 4'h0;
      blue_o        <= 4'h0;
    end else begin
      de_o          <= act1;
      hsync_o       <= hs1 ? HSYNC_POL : ~HSYNC_POL;
      vsync_o       <= vs1 ? VSYNC_POL : ~VSYNC_POL;
      frame_start_o <= fs1;
      if (act1) begin
        {red_o, green_o, blue_o} <= data_i;
      end else begin
        {red_o, green_o, blue_o} <= 12'h000;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized bench for vga_timing_ctrl on a shrunken raster, against a position-based reference model.
module tb_vga_timing_ctrl;

  localparam int HA = 16, HF = 3, HS = 5, HB = 4;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam bit HP = 1'b1;
  localparam bit VP = 1'b0;

  logic        clk_v = 1'b0;
  logic        resetn_v = 1'b1;
  logic        en_i = 1'b0;
  logic [11:0] data_i = 12'h000;
  logic        data_req_o, hsync_o, vsync_o, de_o, frame_start_o;
  logic [3:0]  red_o, green_o, blue_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(HP), .VSYNC_POL(VP), .CNT_W(6)
  ) dut (
    .clk_v(clk_v), .resetn_v(resetn_v), .en_i(en_i), .data_i(data_i),
    .data_req_o(data_req_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o), .frame_start_o(frame_start_o)
  );

  always #5 clk_v = ~clk_v;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic fs;
  } st_t;

  // Model: running flag plus linear position within the frame; pins lag the position by two edges.
  bit          m_run;
  int          m_p;
  st_t         m_s1;
  logic [15:0] m_out;

  localparam logic [16:0] RST_VEC = {1'b0, 1'b0, ~HP, ~VP, 1'b0, 12'h000};

  function automatic st_t decode(bit run, int p);
    st_t s;
    int h, v;
    h = p % HT;
    v = p / HT;
    s.act = run && h < HA && v < VA;
    s.hs  = run && h >= HA + HF && h < HA + HF + HS;
    s.vs  = run && v >= VA + VF && v < VA + VF + VS;
    s.fs  = run && p == 0;
    return s;
  endfunction

  function automatic logic [16:0] exp_vec();
    st_t s0;
    s0 = decode(m_run, m_p);
    return {s0.act, m_out};
  endfunction

  function automatic logic [16:0] obs();
    return {data_req_o, de_o, hsync_o, vsync_o, frame_start_o, red_o, green_o, blue_o};
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_p   = 0;
    m_s1  = '0;
    m_out = {1'b0, ~HP, ~VP, 1'b0, 12'h000};
  endtask

  task automatic step();
    logic e, r;
    logic [11:0] d;
    st_t s0;
    e  = en_i;
    r  = resetn_v;
    d  = data_i;
    s0 = decode(m_run, m_p);
    @(posedge clk_v);
    cyc++;
    if (!r) begin
      model_reset();
    end else begin
      m_out = {m_s1.act, (m_s1.hs ? HP : ~HP), (m_s1.vs ? VP : ~VP), m_s1.fs,
               (m_s1.act ? d : 12'h000)};
      m_s1 = s0;
      if (!m_run) begin
        if (e) begin
          m_run = 1'b1;
          m_p   = 0;
        end
      end else if (m_p == FRAME - 1) begin
        m_p = 0;
        if (!e) m_run = 1'b0;
      end else begin
        m_p++;
      end
    end
    #1;
    data_i = 12'($urandom);
  endtask

  task automatic test_reset();
    int first_req, first_de, first_fs;
    model_reset();
    en_i = 1'b1;
    #1 resetn_v = 1'b0;
    #1;
    checks++;
    if (obs() !== RST_VEC) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", obs(), RST_VEC);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs() !== RST_VEC) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, obs(), RST_VEC);
      end
    end
    resetn_v = 1'b1;
    #1;
    checks++;
    if (data_req_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle data_req got=%b exp=0", data_req_o);
    end
    first_req = -1; first_de = -1; first_fs = -1;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
      end
      if (first_req < 0 && data_req_o === 1'b1) first_req = k;
      if (first_de < 0 && de_o === 1'b1) first_de = k;
      if (first_fs < 0 && frame_start_o === 1'b1) first_fs = k;
    end
    checks++;
    if (first_req != 1 || first_de != 3 || first_fs != 3) begin
      failures++;
      $display("FAIL reset_latency got req=%0d de=%0d fs=%0d exp req=1 de=3 fs=3",
               first_req, first_de, first_fs);
    end
  endtask

  task automatic test_frame();
    int n_req = 0, n_de = 0, n_hs = 0, n_vs = 0, n_fs = 0;
    en_i = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL frame cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
      end
      if (data_req_o === 1'b1) n_req++;
      if (de_o === 1'b1) n_de++;
      if (hsync_o === HP) n_hs++;
      if (vsync_o === VP) n_vs++;
      if (frame_start_o === 1'b1) n_fs++;
    end
    checks++;
    if (n_req != 2 * HA * VA || n_de != 2 * HA * VA) begin
      failures++;
      $display("FAIL frame_req_count got req=%0d de=%0d exp=%0d", n_req, n_de, 2 * HA * VA);
    end
    checks++;
    if (n_hs != 2 * VT * HS || n_vs != 2 * VS * HT) begin
      failures++;
      $display("FAIL frame_sync_count got hs=%0d vs=%0d exp hs=%0d vs=%0d",
               n_hs, n_vs, 2 * VT * HS, 2 * VS * HT);
    end
    checks++;
    if (n_fs != 2) begin
      failures++;
      $display("FAIL frame_start_count got=%0d exp=2", n_fs);
    end
  endtask

  task automatic test_en_drop();
    int target, n_req, exp_req, h, v;
    bit done;
    en_i = 1'b1;
    target = $urandom_range(2 * HT, (VA - 1) * HT - 1);
    for (int i = 0; i < FRAME + 4 && m_p != target; i++) begin
      step();
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL en_drop_pre cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
      end
    end
    h = target % HT;
    v = target / HT;
    exp_req = HA * VA - (v * HA + ((h < HA) ? h : HA));
    n_req = 0;
    done = 1'b0;
    for (int i = 0; i < 2 * FRAME && !done; i++) begin
      en_i = (m_p == FRAME - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      if (data_req_o === 1'b1) n_req++;
      step();
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL en_drop cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
      end
      done = !m_run;
    end
    checks++;
    if (n_req != exp_req) begin
      failures++;
      $display("FAIL en_drop_remaining got=%0d exp=%0d", n_req, exp_req);
    end
    en_i = 1'b0;
    for (int i = 0; i < 3 * HT; i++) begin
      step();
      checks++;
      if (i >= 2 && obs() !== RST_VEC) begin
        failures++;
        $display("FAIL idle_quiet cyc=%0d got=%h exp=%h", cyc, obs(), RST_VEC);
      end else if (i < 2 && obs() !== exp_vec()) begin
        failures++;
        $display("FAIL idle_drain cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    en_i = 1'b1;
    n = $urandom_range(HT * 2, FRAME - 20);
    for (int i = 0; i < n; i++) begin
      step();
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL mid_pre cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
      end
    end
    #2 resetn_v = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs() !== RST_VEC) begin
      failures++;
      $display("FAIL mid_reset_async got=%h exp=%h", obs(), RST_VEC);
    end
    step();
    resetn_v = 1'b1;
    for (int i = 0; i < 2 * HT; i++) begin
      step();
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL mid_restart cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
      end
    end
  endtask

  task automatic test_random_en();
    for (int i = 0; i < 3 * FRAME; i++) begin
      en_i = ($urandom_range(0, 3) != 0);
      step();
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL random_en cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_en_drop();
    test_reset_mid();
    test_random_en();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- VGA Control (VC) stage; sits directly downstream of the ping-pong line buffer.
- Generates horizontal and vertical raster timing.
- Issues one data_req_o per active pixel to the buffer, which returns 12-bit RGB444 one cycle later.
- Drives registered hsync, vsync, data-enable and 4/4/4 colour outputs to the VGA DAC/pins, with all outputs mutually aligned.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync_o (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync_o
- CNT_W, 12, width of h/v counters; H_TOTAL and V_TOTAL must each be at most 2^CNT_W

Ports:
- clk_v  input  1  pixel clock
- resetn_v  input  1  asynchronous active-low reset
- en_i  input  1  display enable from config unit
- data_i  input  12  pixel from buffer, {R[11:8],G[7:4],B[3:0]}, valid the cycle after data_req_o
- data_req_o  output  1  pixel request to buffer
- hsync_o  output  1  horizontal sync
- vsync_o  output  1  vertical sync
- de_o  output  1  active-video indicator, aligned with colour outputs
- red_o  output  4  red
- green_o  output  4  green
- blue_o  output  4  blue
- frame_start_o  output  1  one-cycle pulse, aligned with first active pixel on outputs

Behaviour:
- Reset is asynchronous and active-low on resetn_v; one clock domain, clk_v.
- Derived totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- State machine IDLE/RUN, one-hot or binary.
  - IDLE: h_cnt = 0, v_cnt = 0, no requests.
  - IDLE -> RUN when en_i = 1 is sampled.
  - RUN -> IDLE only at the frame wrap (h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1) when en_i = 0. A frame in progress always completes.
  - Otherwise RUN stays in RUN and the frame wraps to (0,0).
- Counters in RUN:
  - h_cnt increments each cycle and wraps H_TOTAL-1 -> 0.
  - v_cnt increments on the h wrap and wraps V_TOTAL-1 -> 0.
  - Counters are unsigned, CNT_W bits, and are never allowed to exceed TOTAL-1.
- Stage-0 decode (from counter registers), all gated by RUN:
  - act0 = h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - hs0 = H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC.
  - vs0 = V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_SYNC.
- data_req_o = act0.
  - Decoded from registered state only; no combinational path from any input.
  - Exactly H_ACTIVE*V_ACTIVE requests per frame, never in blanking.
- Pipeline stage 1: act1, hs1, vs1, fs1 registered from stage 0. data_i is valid in this stage.
- Pipeline stage 2 (outputs, all registered):
  - de_o <= act1.
  - hsync_o <= hs1 ? HSYNC_POL : ~HSYNC_POL.
  - vsync_o <= vs1 ? VSYNC_POL : ~VSYNC_POL.
  - frame_start_o <= fs1.
  - {red_o,green_o,blue_o} <= act1 ? data_i : 12'h000. Blanking is forced black.
- fs0 = 1 at h_cnt = 0, v_cnt = 0 in RUN.
- Latency: counter position to pins is 2 cycles for every output. The colour of request N appears on the pins 2 cycles after that request.
- Reset values:
  - data_req_o = 0, de_o = 0, frame_start_o = 0, red_o = green_o = blue_o = 0.
  - hsync_o = ~HSYNC_POL, vsync_o = ~VSYNC_POL.
  - State IDLE, counters 0, pipeline registers 0/deasserted.
- Reset mid-frame: all state clears immediately (asynchronously); outputs go to reset values; no partial request afterward. The buffer is reset by the same domain reset.
- en_i toggled mid-frame: ignored until the frame wrap.
- en_i already high out of reset: the first RUN cycle is (0,0), and data_req_o is asserted in that cycle.
- In IDLE: sync outputs are held deasserted and de_o = 0.

Test Plan:
- Reset asserted with en_i = 1, then release -> during reset all outputs hold reset values (hsync_o = vsync_o = 1); first cycle after release is IDLE; data_req_o rises the cycle after that; de_o and frame_start_o rise 2 cycles after data_req_o.
- One full frame at defaults -> 307200 data_req_o pulses; 640 per line in contiguous runs; 160 idle cycles per line; 45 lines with no requests.
- Sync timing -> hsync_o low for 96 cycles starting 656 cycles (+2 latency) after line start; vsync_o low for lines 490-491 (1600 cycles); line period 800; frame period 420000 cycles.
- Data alignment: drive data_i = low 12 bits of a request counter -> pixel k of line shows {r,g,b} = k[11:0] with de_o = 1; 12'h000 appears whenever de_o = 0.
- en_i dropped at line 100 -> frame completes (remaining requests still issued); returns to IDLE after (799,524); no further requests; hsync_o/vsync_o stay 1.
- resetn_v pulsed low at (300,200) -> outputs reset immediately; restart from (0,0) with frame_start_o at latency 2.
